// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with an embedded
// backing-memory model. A read miss pays a fixed MISS_LATENCY-cycle fill penalty;
// writes always go straight to backing memory and complete in two cycles.
module data_cache #(
  parameter int WORD_SIZE      = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 1024,
  parameter int MISS_LATENCY   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic                 readable,
  input  logic                 writable,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 over
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int TAG_W = AW - OFF_W - IDX_W;
  localparam int CNT_W = $clog2(MISS_LATENCY + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]           state;
  logic [AW-1:0]        req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_wr;
  logic [CNT_W-1:0]     cnt;

  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tags    [LINES];
  logic [WORD_SIZE-1:0] lines_q [LINES][WORDS_PER_LINE];
  logic [WORD_SIZE-1:0] mem     [MEM_WORDS] = '{default: '0};

  logic [OFF_W-1:0]     req_off;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic                 wr_lookup;
  logic                 fill_done;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[AW-1 -: TAG_W];
  assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);
  assign wr_lookup = (state == LOOKUP) && req_wr;
  assign fill_done = (state == FILL) && (cnt == CNT_W'(1));

  // Address bits above the backing-memory range are deliberately ignored
  if (WORD_SIZE > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[WORD_SIZE-1:AW];
  end

  // Storage arrays: write-through stores, write-hit line update, whole-line fill
  always_ff @(posedge clk) begin
    if (!rst && wr_lookup) begin
      mem[req_addr] <= req_wdata;
      if (hit) lines_q[req_idx][req_off] <= req_wdata;
    end
    if (!rst && fill_done) begin
      for (int unsigned j = 0; j < WORDS_PER_LINE; j++)
        lines_q[req_idx][j] <= mem[{req_tag, req_idx, OFF_W'(j)}];
      tags[req_idx] <= req_tag;
    end
  end

  // Request FSM, valid bits, miss counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      over      <= 1'b0;
      read_data <= '0;
      valid     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readable | writable) begin
            req_addr  <= addr[AW-1:0];
            req_wdata <= write_data;
            req_wr    <= writable;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_wr) begin
            read_data <= req_wdata;
            over      <= 1'b1;
            state     <= DONE;
          end else if (hit) begin
            read_data <= lines_q[req_idx][req_off];
            over      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt   <= CNT_W'(MISS_LATENCY);
            state <= FILL;
          end
        end
        FILL: begin
          // The requested word is taken straight from memory, since the line
          // array is being written on this same edge.
          if (cnt == CNT_W'(1)) begin
            valid[req_idx] <= 1'b1;
            read_data      <= mem[req_addr];
            over           <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (!(readable | writable)) begin
            over  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus predicts each response from a
// word-level memory/residency model; a monitor checks data and latency on over.
module tb_data_cache;

  localparam int W   = 32;
  localparam int LN  = 16;
  localparam int WPL = 4;
  localparam int MW  = 1024;
  localparam int ML  = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] addr;
  logic         readable;
  logic         writable;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;
  logic         over;

  data_cache #(
    .WORD_SIZE(W),
    .LINES(LN),
    .WORDS_PER_LINE(WPL),
    .MEM_WORDS(MW),
    .MISS_LATENCY(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .readable(readable),
    .writable(writable),
    .write_data(write_data),
    .read_data(read_data),
    .over(over)
  );

  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  due;
    string        name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] mem_m [MW];
  bit          res_v [LN];
  int unsigned res_line [LN];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model_residency();
    for (int i = 0; i < LN; i++) res_v[i] = 1'b0;
  endtask

  task automatic issue(input string name, input bit wr, input bit rd,
                       input logic [W-1:0] a, input logic [W-1:0] d, input int hold);
    int unsigned ea, ln, idx;
    bit hit;
    exp_t e;
    int n;
    @(negedge clk);
    ea  = a % MW;
    ln  = ea / WPL;
    idx = ln % LN;
    hit = res_v[idx] && (res_line[idx] == ln);
    e.name = name;
    if (wr) begin
      mem_m[ea] = d;
      e.data = d;
      e.due  = edges + 2;
    end else begin
      e.data = mem_m[ea];
      e.due  = edges + (hit ? 2 : ML + 2);
      if (!hit) begin
        res_v[idx]    = 1'b1;
        res_line[idx] = ln;
      end
    end
    sb.push_back(e);
    addr = a; write_data = d; writable = wr; readable = rd;
    n = 0;
    while (over !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (over !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: over still %b after %0d cycles, required 1", name, over, n);
      if (sb.size() > 0) void'(sb.pop_back());
    end else begin
      for (int h = 0; h < hold; h++) begin
        addr = $urandom; write_data = $urandom;
        @(negedge clk);
        check({name, "_hold_data"}, read_data, e.data);
        check({name, "_hold_over"}, {31'd0, over}, 32'd1);
      end
    end
    readable = 1'b0; writable = 1'b0;
    @(negedge clk);
    check({name, "_release"}, {31'd0, over}, 32'd0);
  endtask

  task automatic reset_midfill(input logic [W-1:0] a);
    bit bad;
    @(negedge clk);
    addr = a; readable = 1'b1; writable = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; readable = 1'b0;
    clear_model_residency();
    check("midfill_rst_over", {31'd0, over}, 32'd0);
    check("midfill_rst_rdata", read_data, 32'd0);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (over !== 1'b0) bad = 1'b1;
    end
    check("midfill_quiet", {31'd0, bad}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; readable = 1'b1; writable = 1'b0; addr = '0; write_data = '0;
    for (int i = 0; i < MW; i++) mem_m[i] = '0;
    clear_model_residency();

    fork
      begin : monitor
        bit   prev;
        exp_t m;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (over === 1'b1 && !prev) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_over: over=1 at edge %0d, required 0", edges);
            end else begin
              m = sb.pop_front();
              check({m.name, "_data"}, read_data, m.data);
              check({m.name, "_latency"}, edges, m.due);
            end
          end
          prev = (over === 1'b1);
        end
      end
    join_none

    // Reset held with a request pending: the request must not be taken
    repeat (3) @(negedge clk);
    check("reset_over", {31'd0, over}, 32'd0);
    check("reset_rdata", read_data, 32'd0);
    rst = 1'b0; readable = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_over", {31'd0, over}, 32'd0);

    issue("cold_rd0",   1'b0, 1'b1, 32'd0,  32'd0, 1);
    issue("wr1_both",   1'b1, 1'b1, 32'd1,  32'b111101, 2);
    issue("rd1_hit",    1'b0, 1'b1, 32'd1,  32'd0, 0);
    issue("rd2_hit",    1'b0, 1'b1, 32'd2,  32'd0, 0);
    issue("wr64_miss",  1'b1, 1'b0, 32'd64, 32'hDEADBEEF, 0);
    issue("rd0_still",  1'b0, 1'b1, 32'd0,  32'd0, 0);
    issue("rd64_miss",  1'b0, 1'b1, 32'd64, 32'd0, 1);
    issue("rd0_evict",  1'b0, 1'b1, 32'd0,  32'd0, 0);
    issue("rd_alias_hi",1'b0, 1'b1, 32'h0001_0041, 32'd0, 0);
    reset_midfill(32'd5);
    issue("refill5",    1'b0, 1'b1, 32'd5,  32'd0, 0);

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] a;
      bit wr, rd;
      a  = ($urandom_range(3) == 0) ? $urandom : W'($urandom_range(255));
      wr = ($urandom_range(2) == 0);
      rd = wr ? bit'($urandom_range(1)) : 1'b1;
      issue("rnd", wr, rd, a, $urandom, $urandom_range(2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
